// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide engine with HI/LO registers.
// One iteration per clock; operands are latched on start so the caller may change them.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   a_org_q, a_org_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic               bz_q, bz_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dbz_q, dbz_d;

   // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_neg;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic               rem_ge;
   logic               sgn_op, in_sa, in_sb;
   logic [WIDTH-1:0]   mag_a, mag_b;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      rem_ge   = rem_sh >= {1'b0, opnd_q};
      rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
      div_nxt  = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      prod_neg = -acc_q;
      sgn_op   = ~op[0];
      in_sa    = sgn_op & a[WIDTH-1];
      in_sb    = sgn_op & b[WIDTH-1];
      mag_a    = in_sa ? -a : a;
      mag_b    = in_sb ? -b : b;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      a_org_d = a_org_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bz_d    = bz_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               sa_d    = in_sa;
               sb_d    = in_sb;
               a_org_d = a;
               bz_d    = (b == '0);
               // div keeps the dividend in the low half; mult keeps the multiplier there
               opnd_d  = op[1] ? mag_b : mag_a;
               acc_d   = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
               cnt_d   = '0;
               state_d = CALC;
            end else begin
               if (wr_hi) hi_d = wr_data;
               if (wr_lo) lo_d = wr_data;
            end
         end
         CALC: begin
            acc_d = op_q[1] ? div_nxt : mul_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = FINISH;
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (!op_q[1]) begin
               {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
            end else if (bz_q) begin
               lo_d  = '1;
               hi_d  = a_org_q;
               dbz_d = 1'b1;
            end else begin
               lo_d = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         a_org_q <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         a_org_q <= a_org_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
